reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 87 ++++++++
 tb/tb_reg_file.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32 x WIDTH register file: one write port, two combinational read ports.
// X31 reads as zero, and same-cycle write-to-read forwarding is optional.
module reg_file #(
    parameter int WIDTH  = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam int         NREG     = 32;
    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [NREG-1:0]  wr_en;
    logic [WIDTH-1:0] regs_q [0:NREG-2];
    logic [WIDTH-1:0] regs_d [0:NREG-2];
    logic [WIDTH-1:0] words  [0:NREG-1];
    logic [4:0]       rd_addr [0:1];
    logic [WIDTH-1:0] rd_data [0:1];

    always_comb begin : wr_decode
        wr_en = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_en[i] = RegWrite && (WriteRegister == 5'(i));
        end
        wr_en[ZERO_REG] = 1'b0;
    end

    // X31 has no storage; its mux leaf is tied to zero.
    for (genvar r = 0; r < NREG - 1; r++) begin : g_reg
        assign regs_d[r] = wr_en[r] ? WriteData : regs_q[r];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs_q[r] <= '0;
            end else begin
                regs_q[r] <= regs_d[r];
            end
        end

        assign words[r] = regs_q[r];
    end
    assign words[NREG-1] = '0;

    assign rd_addr[0] = ReadRegister1;
    assign rd_addr[1] = ReadRegister2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [WIDTH-1:0] lvl16 [0:15];
        logic [WIDTH-1:0] lvl8  [0:7];
        logic [WIDTH-1:0] lvl4  [0:3];
        logic [WIDTH-1:0] lvl2  [0:1];
        logic [WIDTH-1:0] root;
        logic             hit;

        // Binary mux tree, LSB of the address selects at the leaf level.
        for (genvar j = 0; j < 16; j++) begin : g_l16
            assign lvl16[j] = rd_addr[p][0] ? words[2*j+1] : words[2*j];
        end
        for (genvar j = 0; j < 8; j++) begin : g_l8
            assign lvl8[j] = rd_addr[p][1] ? lvl16[2*j+1] : lvl16[2*j];
        end
        for (genvar j = 0; j < 4; j++) begin : g_l4
            assign lvl4[j] = rd_addr[p][2] ? lvl8[2*j+1] : lvl8[2*j];
        end
        for (genvar j = 0; j < 2; j++) begin : g_l2
            assign lvl2[j] = rd_addr[p][3] ? lvl4[2*j+1] : lvl4[2*j];
        end
        assign root = rd_addr[p][4] ? lvl2[1] : lvl2[0];

        // Forwarding is not gated by reset, so WriteData can appear while reset is high.
        assign hit = BYPASS && RegWrite && (WriteRegister == rd_addr[p])
                     && (WriteRegister != ZERO_REG);
        assign rd_data[p] = hit ? WriteData : root;
    end

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: one BYPASS=1 and one BYPASS=0 instance
// share the same stimulus and are compared against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [63:0] WriteData = '0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [63:0] obs [4];

    logic [63:0] model [32];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reg_file #(.WIDTH(64), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_b), .ReadData2(rd2_b)
    );

    reg_file #(.WIDTH(64), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_n), .ReadData2(rd2_n)
    );

    assign obs[0] = rd1_b;
    assign obs[1] = rd2_b;
    assign obs[2] = rd1_n;
    assign obs[3] = rd2_n;

    // Architectural view: a pending write is visible only on the bypassing
    // instance, address 31 is always zero, otherwise the stored value.
    function automatic logic [63:0] expect_rd(input bit byp, input logic [4:0] ra);
        if (byp && RegWrite && WriteRegister == ra && WriteRegister != 5'd31)
            return WriteData;
        if (ra == 5'd31)
            return 64'd0;
        return model[ra];
    endfunction

    task automatic edge_commit();
        @(posedge clk);
        if (RegWrite && !reset && WriteRegister != 5'd31)
            model[WriteRegister] = WriteData;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = a;
        WriteData = d;
        edge_commit();
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
    endtask

    task automatic test_reset();
        logic [63:0] exp;
        clear_model();
        #2;
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            for (int k = 0; k < 4; k++) begin
                exp = 64'd0;
                total++;
                if (obs[k] !== exp) begin
                    bad++;
                    $display("FAIL reset_read port=%0d addr=%0d got=%h exp=%h", k, a, obs[k], exp);
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_write();
        wr(5'd5, 64'h0123_4567_89AB_CDEF);
        wr(5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd6;
        #1;
        total += 4;
        if (rd1_b !== 64'h0123_4567_89AB_CDEF || rd1_n !== 64'h0123_4567_89AB_CDEF) begin
            bad++;
            $display("FAIL basic_x5 got=%h/%h exp=0123456789abcdef", rd1_b, rd1_n);
        end
        if (rd2_b !== 64'hFFFF_FFFF_FFFF_FFFF || rd2_n !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL basic_x6 got=%h/%h exp=ffffffffffffffff", rd2_b, rd2_n);
        end
        ReadRegister1 = 5'd4;
        ReadRegister2 = 5'd7;
        #1;
        if (rd1_b !== 64'd0 || rd1_n !== 64'd0) begin
            bad++;
            $display("FAIL basic_x4 got=%h/%h exp=0", rd1_b, rd1_n);
        end
        if (rd2_b !== 64'd0 || rd2_n !== 64'd0) begin
            bad++;
            $display("FAIL basic_x7 got=%h/%h exp=0", rd2_b, rd2_n);
        end
    endtask

    task automatic test_x31();
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd31;
        WriteData = 64'hDEAD_BEEF;
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd31;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs[k] !== 64'd0) begin
                bad++;
                $display("FAIL x31_pre port=%0d got=%h exp=0", k, obs[k]);
            end
        end
        edge_commit();
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs[k] !== 64'd0) begin
                bad++;
                $display("FAIL x31_post port=%0d got=%h exp=0", k, obs[k]);
            end
        end
    endtask

    task automatic test_no_write();
        logic [63:0] prior;
        prior = {$urandom, $urandom};
        wr(5'd3, prior);
        RegWrite = 1'b0;
        WriteRegister = 5'd3;
        WriteData = 64'h1234;
        edge_commit();
        @(negedge clk);
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd3;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs[k] !== prior) begin
                bad++;
                $display("FAIL no_write_x3 port=%0d got=%h exp=%h", k, obs[k], prior);
            end
        end
    endtask

    task automatic test_bypass();
        logic [63:0] old;
        old = {$urandom, $urandom};
        wr(5'd10, old);
        RegWrite = 1'b1;
        WriteRegister = 5'd10;
        WriteData = 64'hA5A5;
        ReadRegister1 = 5'd10;
        ReadRegister2 = 5'd10;
        #1;
        total += 4;
        if (rd1_b !== 64'hA5A5) begin bad++; $display("FAIL bypass_pre_p1 got=%h exp=a5a5", rd1_b); end
        if (rd2_b !== 64'hA5A5) begin bad++; $display("FAIL bypass_pre_p2 got=%h exp=a5a5", rd2_b); end
        if (rd1_n !== old) begin bad++; $display("FAIL nobypass_pre_p1 got=%h exp=%h", rd1_n, old); end
        if (rd2_n !== old) begin bad++; $display("FAIL nobypass_pre_p2 got=%h exp=%h", rd2_n, old); end
        edge_commit();
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs[k] !== 64'hA5A5) begin
                bad++;
                $display("FAIL bypass_post port=%0d got=%h exp=a5a5", k, obs[k]);
            end
        end
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] exp;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            RegWrite = 1'($urandom_range(0, 1));
            WriteRegister = 5'($urandom);
            WriteData = {$urandom, $urandom};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            #1;
            for (int k = 0; k < 4; k++) begin
                exp = expect_rd(k < 2, (k % 2 == 0) ? ReadRegister1 : ReadRegister2);
                total++;
                if (obs[k] !== exp) begin
                    bad++;
                    $display("FAIL random n=%0d port=%0d we=%0d wa=%0d r1=%0d r2=%0d got=%h exp=%h",
                             n, k, RegWrite, WriteRegister, ReadRegister1, ReadRegister2, obs[k], exp);
                end
            end
            edge_commit();
        end
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [63:0] exp;
        for (int i = 0; i < 31; i++) wr(5'(i), 64'(i + 1));
        // Assert reset between edges while a write is pending.
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd4;
        WriteData = 64'hBAD;
        #2;
        reset = 1'b1;
        clear_model();
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(a);
            #1;
            for (int k = 0; k < 4; k++) begin
                exp = expect_rd(k < 2, 5'(a));
                total++;
                if (obs[k] !== exp) begin
                    bad++;
                    $display("FAIL async_reset port=%0d addr=%0d got=%h exp=%h", k, a, obs[k], exp);
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        RegWrite = 1'b0;
        wr(5'd2, 64'h7);
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            for (int k = 0; k < 4; k++) begin
                exp = ((k % 2 == 0) ? a : 31 - a) == 2 ? 64'h7 : 64'd0;
                total++;
                if (obs[k] !== exp) begin
                    bad++;
                    $display("FAIL post_reset_write port=%0d addr=%0d got=%h exp=%h",
                             k, (k % 2 == 0) ? a : 31 - a, obs[k], exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_x31();
        test_no_write();
        test_bypass();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
